// File: rtl/fir_sample_feeder_if.sv
// Sample-buffer write port plus the FIR-facing sample/strobe pair.
// The feeder takes the slave side; whoever loads samples and consumes the strobe takes the master side.
interface fir_sample_feeder_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] sample_out;
  logic          go_out;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  sample_out, go_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output sample_out, go_out
  );
endinterface

// File: rtl/fir_sample_feeder.sv
// Plays stored samples into the FIR in/go interface.
// Each sample is held for one cycle, then strobed, then followed by a programmable gap.
module fir_sample_feeder #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8,
  parameter int CW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  fir_sample_feeder_if.slave  bus,
  input  logic [AW:0]         len,
  input  logic [CW-1:0]       interval,
  input  logic                loop,
  input  logic                start,
  input  logic                stop,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {IDLE, LOAD, STROBE, GAP, DONE} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic [CW-1:0] interval_q, interval_d;
  logic          loop_q, loop_d;
  logic [DW-1:0] sample_q, sample_d;
  logic          go_q, go_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          end_of_sample;

  logic [DW-1:0] mem_q [DEPTH];

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    interval_d    = interval_q;
    loop_d        = loop_q;
    sample_d      = sample_q;
    end_of_sample = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop && len != '0) begin
          state_d    = LOAD;
          len_d      = (len > DEPTH_L) ? DEPTH_L : len;
          interval_d = interval;
          loop_d     = loop;
          idx_d      = '0;
        end
      end
      LOAD:   state_d = STROBE;
      STROBE: begin
        if (interval_q != '0) begin
          state_d = GAP;
          cnt_d   = interval_q;
        end else begin
          end_of_sample = 1'b1;
        end
      end
      GAP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) end_of_sample = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (end_of_sample) begin
      if ({1'b0, idx_q} < len_q - 1'b1) begin
        idx_d   = idx_q + 1'b1;
        state_d = LOAD;
      end else if (loop_q) begin
        idx_d   = '0;
        state_d = LOAD;
      end else begin
        state_d = DONE;
      end
    end

    // Abort wins over every sequencing decision made above.
    if (stop && (state_q == LOAD || state_q == STROBE || state_q == GAP)) begin
      state_d = IDLE;
    end

    if (state_d == LOAD) sample_d = mem_q[idx_d];
    go_d   = (state_d == STROBE);
    busy_d = (state_d == LOAD) || (state_d == STROBE) || (state_d == GAP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      interval_q <= '0;
      loop_q     <= 1'b0;
      sample_q   <= '0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      interval_q <= interval_d;
      loop_q     <= loop_d;
      sample_q   <= sample_d;
      go_q       <= go_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Buffer survives reset and only accepts writes while playback is not running.
  always_ff @(posedge clk) begin
    if (bus.wr_en && (state_q == IDLE || state_q == DONE)) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.sample_out = sample_q;
  assign bus.go_out     = go_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder: one-shot, gapped, looped, abort, reset and write-lockout cases.
module tb_fir_sample_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] len;
  logic [7:0] interval;
  logic       loop;
  logic       start;
  logic       stop;
  logic       busy;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] model_mem [8];

  fir_sample_feeder_if #(.AW(3), .DW(8)) bus ();

  fir_sample_feeder #(.DEPTH(8), .AW(3), .DW(8), .CW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .len      (len),
    .interval (interval),
    .loop     (loop),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic writeSample(input logic [2:0] addr, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Returns one cycle after the edge that samples start, i.e. in cycle 1.
  task automatic applyStimulus(input int l, input int i, input logic lp, input logic st, input logic sp);
    len      = 4'(l);
    interval = 8'(i);
    loop     = lp;
    start    = st;
    stop     = sp;
    tick();
    start    = 1'b0;
    stop     = 1'b0;
  endtask

  task automatic playCheck(input int l, input int i);
    int leff;
    int p;
    int total;
    int strobes;
    logic [7:0] exp_s;
    leff    = (l > 8) ? 8 : l;
    p       = 2 + i;
    total   = leff * p + 2;
    strobes = 0;
    applyStimulus(l, i, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= total; c++) begin
      int k;
      int ph;
      k  = (c - 1) / p;
      ph = (c - 1) % p;
      if (k < leff) begin
        exp_s = model_mem[k];
        checkOutput($sformatf("go l%0d i%0d c%0d", l, i, c), bus.go_out, (ph == 1));
        checkOutput($sformatf("busy l%0d i%0d c%0d", l, i, c), busy, 1);
        checkOutput($sformatf("done l%0d i%0d c%0d", l, i, c), done, 0);
      end else begin
        exp_s = model_mem[leff-1];
        checkOutput($sformatf("go l%0d i%0d c%0d", l, i, c), bus.go_out, 0);
        checkOutput($sformatf("busy l%0d i%0d c%0d", l, i, c), busy, 0);
        checkOutput($sformatf("done l%0d i%0d c%0d", l, i, c), done, (c == leff * p + 1));
      end
      checkOutput($sformatf("sample l%0d i%0d c%0d", l, i, c), bus.sample_out, exp_s);
      if (bus.go_out) strobes++;
      tick();
    end
    checkOutput($sformatf("strobes l%0d i%0d", l, i), strobes, leff);
  endtask

  initial begin
    rst         = 1'b1;
    len         = '0;
    interval    = '0;
    loop        = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    tick();
    tick();
    checkOutput("rst sample", bus.sample_out, 0);
    checkOutput("rst go", bus.go_out, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst done", done, 0);
    rst = 1'b0;
    tick();
    checkOutput("post-rst busy", busy, 0);

    for (int a = 0; a < 8; a++) begin
      model_mem[a] = 8'(a + 1);
      writeSample(3'(a), 8'(a + 1));
    end

    $display("[TB] one-shot len=3 interval=0");
    playCheck(3, 0);
    $display("[TB] one-shot len=3 interval=3");
    playCheck(3, 3);

    $display("[TB] loop len=2 interval=1 then stop in GAP");
    applyStimulus(2, 1, 1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      int k;
      int ph;
      k  = ((c - 1) / 3) % 2;
      ph = (c - 1) % 3;
      checkOutput($sformatf("loop sample c%0d", c), bus.sample_out, model_mem[k]);
      checkOutput($sformatf("loop go c%0d", c), bus.go_out, (ph == 1));
      checkOutput($sformatf("loop busy c%0d", c), busy, 1);
      checkOutput($sformatf("loop done c%0d", c), done, 0);
      if (c < 9) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop busy", busy, 0);
    checkOutput("stop go", bus.go_out, 0);
    checkOutput("stop done", done, 0);
    checkOutput("stop sample held", bus.sample_out, 8'h01);
    tick();
    checkOutput("stop busy+1", busy, 0);
    checkOutput("stop done+1", done, 0);

    $display("[TB] write while busy is ignored");
    applyStimulus(2, 0, 1'b0, 1'b1, 1'b0);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd0;
    bus.wr_data = 8'hAA;
    tick();
    bus.wr_en   = 1'b0;
    checkOutput("wr-busy busy", busy, 1);
    for (int c = 0; c < 5; c++) tick();
    playCheck(1, 0);

    $display("[TB] len=0 start stays idle");
    applyStimulus(0, 0, 1'b0, 1'b1, 1'b0);
    checkOutput("len0 busy", busy, 0);
    checkOutput("len0 go", bus.go_out, 0);
    checkOutput("len0 done", done, 0);
    checkOutput("len0 sample", bus.sample_out, 8'h01);
    tick();
    checkOutput("len0 busy+1", busy, 0);

    $display("[TB] len=12 clamps to 8");
    playCheck(12, 0);

    $display("[TB] reset during STROBE");
    applyStimulus(3, 0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("pre-rst go", bus.go_out, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid-rst go", bus.go_out, 0);
    checkOutput("mid-rst busy", busy, 0);
    checkOutput("mid-rst sample", bus.sample_out, 0);
    checkOutput("mid-rst done", done, 0);
    tick();
    playCheck(3, 1);

    $display("[TB] start with stop in IDLE");
    applyStimulus(3, 0, 1'b0, 1'b1, 1'b1);
    checkOutput("start+stop busy", busy, 0);
    checkOutput("start+stop go", bus.go_out, 0);
    tick();
    checkOutput("start+stop busy+1", busy, 0);
    checkOutput("start+stop go+1", bus.go_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
